piso_serializer: RTL
====================

// Module: piso_serializer
// PURPOSE
//  Parallel-in serial-out transmitter; the opposite direction of the SIPO delay-line capture path.
//  Accepts a WIDTH-bit word over a valid/ready handshake and shifts it onto line_out one bit per bit period.
//  The frame_out strobe qualifies the bit stream for the downstream capture chain.
//  Sits between the control logic and the serial capture stage on the 100 MHz clk domain.
// PARAMETERS
//  WIDTH       8  bits per word (>=2)
//  MSB_FIRST   1  1: bit WIDTH-1 sent first; 0: bit 0 sent first
//  CLK_DIV     1  clk cycles per bit period (>=1)
//  GAP_CYCLES  1  idle cycles forced between frames (>=0)
//  IDLE_LEVEL  0  line_out level outside a frame
// PORTS
//  clk         in   1      system clock, 100 MHz, all logic on rising edge
//  rst         in   1      synchronous reset, active-high
//  data_in     in   WIDTH  word to transmit, sampled on accept
//  data_valid  in   1      producer has a word
//  data_ready  out  1      block can accept; transfer = data_valid & data_ready at rising edge
//  line_out    out  1      serial output, registered
//  frame_out   out  1      high while a data bit is on line_out
//  busy        out  1      high in SHIFT or GAP
//  done        out  1      one-cycle pulse after last bit period of a frame
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE; line_out=IDLE_LEVEL, frame_out=0, busy=0, done=0, data_ready=0.
//   data_ready rises the cycle after rst deasserts.
//  FSM IDLE -> SHIFT -> GAP -> IDLE (GAP skipped when GAP_CYCLES=0).
//  IDLE: data_ready=1. On transfer at edge N, latch data_in into shift reg, go SHIFT.
//   After edge N: line_out=first bit, frame_out=1, busy=1, data_ready=0.
//  SHIFT: each bit held exactly CLK_DIV cycles; bit counter counts 0..WIDTH-1; frame = WIDTH*CLK_DIV cycles.
//   Shift direction set by MSB_FIRST; shift reg fill value irrelevant (not observable).
//  End of last bit period (edge N+WIDTH*CLK_DIV): line_out=IDLE_LEVEL, frame_out=0, done=1 for one cycle;
//   go GAP (busy=1) or, if GAP_CYCLES=0, IDLE (busy=0, data_ready=1 same cycle as done).
//  GAP: hold GAP_CYCLES cycles, line_out=IDLE_LEVEL, then IDLE.
//  Minimum frame-to-frame period: WIDTH*CLK_DIV + GAP_CYCLES + 1 cycles (1 = IDLE accept cycle).
//  data_in/data_valid ignored while data_ready=0; word held by producer until accepted.
//  data_valid low in IDLE: stay IDLE, outputs unchanged.
//  Reset mid-frame: frame aborted immediately, no done pulse, all outputs to reset values.
//  Counters: bit counter $clog2(WIDTH) bits, divider $clog2(CLK_DIV)+1, gap $clog2(GAP_CYCLES+1)+1; no wrap inside a frame.
//  No combinational path from any input to any output except data_ready (pure state decode).
// STRUCTURE
//  serdes_pkg: FSM state localparams (ST_IDLE, ST_SHIFT, ST_GAP), shared with the SIPO capture side.
//  Sub-module bit_tick_gen: CLK_DIV prescaler, sync clear on frame start/rst, emits 1-cycle bit_tick per period.
//  Top: FSM, shift register, bit counter, gap counter, output registers.
// TESTING
//  Reset: hold rst 3 cycles mid-traffic -> line_out=IDLE_LEVEL, frame_out=busy=done=data_ready=0; data_ready=1 one cycle after release.
//  WIDTH=8,MSB_FIRST=1,CLK_DIV=1: send 8'hA5 -> line_out 1,0,1,0,0,1,0,1 on 8 cycles, frame_out=1 for 8 cycles, done 1 cycle after.
//  MSB_FIRST=0,CLK_DIV=4: send 8'h01 -> line_out=1 for 4 cycles then 0 for 28; frame_out high 32 cycles.
//  Back-to-back, GAP_CYCLES=0, data_valid held high, words 8'hFF,8'h00 -> period 9 cycles, one IDLE_LEVEL cycle between frames.
//  GAP_CYCLES=3: data_valid held high -> data_ready low for 3 cycles after done; next accept on 4th cycle.
//  Assert rst at bit 4 of 8'hC3 -> outputs reset next cycle, no done; next word 8'h3C transmits correctly.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared serial-link definitions: FSM state encoding used by both the PISO
// transmitter and the SIPO capture side.
package serdes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } serdes_state_e;

endpackage

// File: rtl/piso_serializer_bit_tick_gen.sv
// Bit-period prescaler: emits a one-cycle bit_tick at the last clk cycle of
// every CLK_DIV-cycle bit period while enabled; clear restarts the period.
module bit_tick_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic bit_tick_o
);

  localparam int CNT_W = $clog2(CLK_DIV) + 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             last_s;

  assign last_s     = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign bit_tick_o = en_i & last_s;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last_s ? '0 : cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts a word over valid/ready and
// shifts it onto line_out, one bit per CLK_DIV cycles, framed by frame_out.
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int CLK_DIV    = 1,
  parameter int GAP_CYCLES = 1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             line_out,
  output logic             frame_out,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W    = $clog2(WIDTH);
  localparam int GAP_W    = $clog2(GAP_CYCLES + 1) + 1;
  localparam int BIT_LAST = WIDTH - 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;

  serdes_state_e    state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             line_q, line_d;
  logic             frame_q, frame_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             accept_s;
  logic             tick_s;

  // ready_q is only ever set while the FSM rests in IDLE
  assign accept_s = ready_q & data_valid & (state_q == ST_IDLE);

  bit_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (accept_s),
    .en_i      (state_q == ST_SHIFT),
    .bit_tick_o(tick_s)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    line_d    = line_q;
    frame_d   = frame_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d   = ST_SHIFT;
          shift_d   = data_in;
          bit_cnt_d = '0;
          line_d    = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
          frame_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (!tick_s) begin
          state_d = ST_SHIFT;
        end else if (bit_cnt_q == BIT_W'(BIT_LAST)) begin
          line_d    = IDLE_LEVEL;
          frame_d   = 1'b0;
          done_d    = 1'b1;
          gap_cnt_d = '0;
          state_d   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else begin
          // Next bit is the neighbour of the one currently on the line
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          shift_d   = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
          line_d    = MSB_FIRST ? shift_q[WIDTH-2] : shift_q[1];
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        line_d  = IDLE_LEVEL;
        frame_d = 1'b0;
      end
    endcase
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      line_q    <= IDLE_LEVEL;
      frame_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      line_q    <= line_d;
      frame_q   <= frame_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign data_ready = ready_q;
  assign line_out   = line_q;
  assign frame_out  = frame_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
